// File: rtl/serial_word_collector_if.sv
// Output-side bundle of serial_word_collector: serial input, word handshake and status flags.
// The collector connects through the master modport; the consumer or bench uses slave.
interface serial_word_collector_if #(
    parameter int WIDTH = 8
);
    logic             si;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             parity_err;

    modport master (
        input  si,
        input  dout_ready,
        output dout,
        output dout_valid,
        output overrun,
        output parity_err
    );

    modport slave (
        output si,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  overrun,
        input  parity_err
    );
endinterface

// File: rtl/serial_word_collector.sv
// Serial-to-parallel frame collector: start bit, WIDTH data bits MSB first, optional even parity.
// Define PARITY_CHECK_EN to add the parity bit and PARITY state; the port list is unchanged either way.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    serial_word_collector_if.master bus
);
    localparam int CW = $clog2(WIDTH);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             last_bit;
    logic             shift_en;
    logic             clr_cnt;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overrun_q;
`ifdef PARITY_CHECK_EN
    logic             word_perr;
    logic             perr_q;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.si) state_next = DATA;
            DATA: begin
                if (last_bit) begin
`ifdef PARITY_CHECK_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        clr_cnt  = 1'b0;
        complete = 1'b0;
        word     = shreg;
`ifdef PARITY_CHECK_EN
        word_perr = 1'b0;
`endif
        case (state)
            IDLE: clr_cnt = 1'b1;
            DATA: begin
                shift_en = 1'b1;
`ifndef PARITY_CHECK_EN
                // Without parity the word completes on the last data bit, so that bit bypasses the shifter.
                if (last_bit) begin
                    complete = 1'b1;
                    word     = {shreg[WIDTH-2:0], bus.si};
                end
`endif
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                complete  = 1'b1;
                word_perr = (^shreg) ^ bus.si;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            if (clr_cnt)       cnt <= '0;
            else if (shift_en) cnt <= last_bit ? '0 : cnt + CW'(1);
            if (shift_en) shreg <= {shreg[WIDTH-2:0], bus.si};

            // A completion loads only if the holding register is empty or being drained this cycle.
            if (complete) begin
                if (!valid_q || bus.dout_ready) begin
                    dout_q  <= word;
                    valid_q <= 1'b1;
`ifdef PARITY_CHECK_EN
                    perr_q  <= word_perr;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: frame vector table plus hand-built corner sequences,
// with accepted words checked against a queue of expected words.
module tb_serial_word_collector;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        int unsigned  gap;
        logic [W-1:0] exp_word;
        logic         exp_perr;
    } vec_t;

    typedef struct {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    serial_word_collector_if #(.WIDTH(W)) bus ();

    serial_word_collector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (bus.dout_valid && bus.dout_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h required no word", bus.dout);
            end else begin
                e = q.pop_front();
                chk("dout", 32'(bus.dout), 32'(e.word));
                chk("parity_err", 32'(bus.parity_err), 32'(e.perr));
            end
        end
    endtask

    // Drive one bit, check the handshake just before the edge, return 1 time unit after it.
    task automatic step(input logic s);
        bus.si = s;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic par);
        logic [W-1:0] d;
        d = data;
        step(1'b1);
        for (int i = W - 1; i >= 0; i--) step(d[i]);
`ifdef PARITY_CHECK_EN
        step(par);
`else
        if (par) ;
`endif
    endtask

    task automatic push(input logic [W-1:0] word, input logic perr);
        exp_t e;
        e.word = word;
`ifdef PARITY_CHECK_EN
        e.perr = perr;
`else
        e.perr = perr & 1'b0;
`endif
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        int unsigned seen;

        tbl = '{
            '{8'h6A, 1'b0, 0, 8'h6A, 1'b0},
            '{8'h6A, 1'b1, 1, 8'h6A, 1'b1},
            '{8'hA5, 1'b0, 0, 8'hA5, 1'b0},
            '{8'h01, 1'b1, 2, 8'h01, 1'b0},
            '{8'h80, 1'b0, 0, 8'h80, 1'b1},
            '{8'hFF, 1'b0, 1, 8'hFF, 1'b0},
            '{8'h00, 1'b1, 0, 8'h00, 1'b1},
            '{8'h3C, 1'b0, 0, 8'h3C, 1'b0},
            '{8'h7E, 1'b1, 2, 8'h7E, 1'b1}
        };

        bus.si = 1'b0;
        bus.dout_ready = 1'b1;
        do_reset();
        chk("reset_dout", 32'(bus.dout), 32'h0);
        chk("reset_valid", 32'(bus.dout_valid), 32'h0);
        chk("reset_overrun", 32'(bus.overrun), 32'h0);
        chk("reset_parity_err", 32'(bus.parity_err), 32'h0);

        // Basic frame: word visible one cycle after the last bit, for exactly one cycle.
        push(8'h6A, 1'b0);
        send_frame(8'h6A, 1'b0);
        chk("latency_valid", 32'(bus.dout_valid), 32'h1);
        chk("latency_dout", 32'(bus.dout), 32'h6A);
        step(1'b0);
        chk("valid_one_cycle", 32'(bus.dout_valid), 32'h0);

        // Back-to-back frames with no idle gap.
        push(8'h6A, 1'b0);
        push(8'hA5, 1'b0);
        send_frame(8'h6A, 1'b0);
        send_frame(8'hA5, 1'b0);
        step(1'b0);
        step(1'b0);
        chk("b2b_overrun", 32'(bus.overrun), 32'h0);

        // Table of frames, ready held high, variable gaps.
        foreach (tbl[k]) begin
            push(tbl[k].exp_word, tbl[k].exp_perr);
            send_frame(tbl[k].data, tbl[k].par);
            for (int unsigned g = 0; g < tbl[k].gap; g++) step(1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("table_drained", 32'(q.size()), 32'h0);

        // Backpressure: second word dropped, first kept, overrun sticky.
        bus.dout_ready = 1'b0;
        push(8'h6A, 1'b0);
        send_frame(8'h6A, 1'b0);
        send_frame(8'h11, 1'b0);
        step(1'b0);
        chk("bp_valid", 32'(bus.dout_valid), 32'h1);
        chk("bp_dout_held", 32'(bus.dout), 32'h6A);
        chk("bp_overrun", 32'(bus.overrun), 32'h1);
        bus.dout_ready = 1'b1;
        step(1'b0);
        chk("bp_valid_drop", 32'(bus.dout_valid), 32'h0);
        chk("bp_overrun_sticky", 32'(bus.overrun), 32'h1);
        do_reset();
        chk("overrun_cleared", 32'(bus.overrun), 32'h0);

        // Reset after start bit plus three data bits discards the partial frame.
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        do_reset();
        chk("midrst_valid", 32'(bus.dout_valid), 32'h0);
        push(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        chk("midrst_dout", 32'(bus.dout), 32'h3C);
        step(1'b0);

        // Idle line: nothing completes, then a frame still decodes correctly.
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            if (bus.dout_valid) seen++;
        end
        chk("idle_no_valid", seen, 0);
        push(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b0);
        chk("post_idle_dout", 32'(bus.dout), 32'hA5);
        step(1'b0);
        step(1'b0);

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_word_collector.md
SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per frame (legal range 2..32).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port si, input, 1 bit: the serial bit stream from the upstream shift-left register output, one bit per clk.
REQ-005 Port dout, output, WIDTH bits: the assembled word, first-received bit in the MSB.
REQ-006 Port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-007 Port dout_ready, input, 1 bit: the consumer accepts dout in any cycle where dout_valid and dout_ready are both 1.
REQ-008 Port overrun, output, 1 bit: sticky flag set when a completed word is dropped.
REQ-009 Port parity_err, output, 1 bit: parity failure flag qualified by dout_valid.

Function
REQ-010 Frame format SHALL be: one start bit (si=1), then WIDTH data bits MSB first, then one parity bit only when PARITY_CHECK_EN is defined; the line idles at 0.
REQ-011 The FSM SHALL have states IDLE, DATA and PARITY; PARITY SHALL exist only when PARITY_CHECK_EN is defined.
REQ-012 IDLE: si=1 sampled -> DATA with bit counter cleared; si=0 -> stay in IDLE.
REQ-013 DATA: each cycle, the shift register SHALL shift left with si entering the LSB, and the counter SHALL increment.
REQ-014 On the cycle sampling data bit WIDTH-1: go to PARITY if enabled, otherwise complete the word and go to IDLE.
REQ-015 PARITY: sample si as the parity bit, complete the word, then go to IDLE.
REQ-016 Word completion SHALL load the holding register, so dout_valid is 1 in the cycle after the last frame bit is sampled (latency 1).
REQ-017 IDLE SHALL accept a new start bit in the cycle right after completion, so back-to-back frames need no gap.
REQ-018 dout and parity_err SHALL hold steady while dout_valid=1 and dout_ready=0.
REQ-019 On completion with dout_valid=1 and dout_ready=0, the new word SHALL be dropped, the old word kept, and overrun set to 1.
REQ-020 On completion in the same cycle as an accept, the new word SHALL load and dout_valid SHALL stay 1.
REQ-021 On an accept with no completion, dout_valid SHALL go to 0 in the next cycle.
REQ-022 overrun SHALL stay 1 until rst.
REQ-023 The bit counter SHALL be clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-024 While rst=1 the block SHALL set the FSM to IDLE and clear the shift register, counter, dout, dout_valid, overrun and parity_err to 0.
REQ-025 rst asserted mid-frame SHALL discard the partial frame; the first si=1 after release starts a new frame.
REQ-026 si SHALL be ignored in any cycle where rst=1.

Configuration
REQ-027 Macro PARITY_CHECK_EN, when defined, SHALL enable the parity bit and the PARITY state.
REQ-028 With PARITY_CHECK_EN, parity is even: parity_err=1 when the XOR of the WIDTH data bits and the parity bit is 1.
REQ-029 Without PARITY_CHECK_EN, the frame is start bit plus WIDTH data bits, and parity_err SHALL be tied to 0.
REQ-030 The port list SHALL be identical with and without PARITY_CHECK_EN.

Verification
REQ-031 Basic frame: WIDTH=8, no macro, dout_ready=1, si=1,0,1,1,0,1,0,1,0 then 0s -> dout=0x6A, dout_valid high for exactly one cycle, 1 cycle after the 9th bit.
REQ-032 Back-to-back: two frames 1+0x6A and 1+0xA5 with no gap -> 0x6A then 0xA5 on consecutive completions, overrun=0.
REQ-033 Backpressure: dout_ready=0, frame 0x6A then frame 0x11 -> dout stays 0x6A, overrun=1; raising dout_ready -> dout_valid=0 on the next cycle.
REQ-034 Reset mid-frame: rst=1 after start bit plus 3 data bits, then frame 1+0x3C -> dout=0x3C, no stale bits.
REQ-035 Parity, with PARITY_CHECK_EN: frame 1+0x6A+parity 0 -> parity_err=0; frame 1+0x6A+parity 1 -> parity_err=1.
REQ-036 Idle line: si=0 for 100 cycles -> dout_valid never asserts and the FSM stays in IDLE.
